// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, the canonical NOP and PC alignment.
// No timing of its own; pure declarations.
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant/response port, one outstanding request.
// Address held stable while req is high and ungranted; one in-order response per grant.
interface fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; empty slot reads as NOP.
// Latency 1 cycle; stall freezes contents, flush inserts a bubble.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        stall,
   input  logic        load_valid,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_instr,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= 32'd0;
         instr <= NOP;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP;
      end else if (!stall) begin
         valid <= load_valid;
         if (load_valid) begin
            pc    <= load_pc;
            instr <= load_instr;
         end else begin
            instr <= NOP;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: PC, one-outstanding imem port, stale-response drain, IF/ID register.
// Grant n / response n+1 gives valid_ID at n+2; stall_IF parks a response in the hold buffer.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP      = NOP_INSTR
) (
   input  logic                 clk,
   input  logic                 rst,
   fetch_stage_if.master        imem,
   input  logic                 stall_IF,
   input  logic                 flush_IF,
   input  logic                 pc_change_EX,
   input  logic [31:0]          pc_target_EX,
   output logic [31:0]          pc_IF,
   output logic                 valid_ID,
   output logic [31:0]          pc_ID,
   output logic [31:0]          instr_ID
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic [31:0]  hold_pc_q, hold_pc_d;
   logic [31:0]  hold_instr_q, hold_instr_d;
   logic         xfer_vld;
   logic [31:0]  xfer_pc;
   logic [31:0]  xfer_instr;
   logic [31:0]  redirect_pc;
   logic         unused_tgt_bits;

   assign redirect_pc     = align_pc(pc_target_EX);
   assign unused_tgt_bits = ^pc_target_EX[1:0];
   assign imem.addr       = pc_IF;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= REQ;
         pc_IF        <= RESET_PC;
         req_pc_q     <= 32'd0;
         hold_pc_q    <= 32'd0;
         hold_instr_q <= NOP;
      end else begin
         state_q      <= state_d;
         pc_IF        <= pc_d;
         req_pc_q     <= req_pc_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_IF;
      req_pc_d     = req_pc_q;
      hold_pc_d    = hold_pc_q;
      hold_instr_d = hold_instr_q;
      imem.req     = 1'b0;
      xfer_vld     = 1'b0;
      xfer_pc      = hold_pc_q;
      xfer_instr   = hold_instr_q;

      case (state_q)
         REQ: begin
            imem.req = 1'b1;
            if (pc_change_EX) begin
               pc_d = redirect_pc;
               // A grant taken this cycle was for the old address; its response must be dropped.
               if (imem.gnt) state_d = DRAIN;
            end else if (imem.gnt) begin
               req_pc_d = pc_IF;
               pc_d     = pc_IF + 32'd4;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (pc_change_EX) begin
               pc_d    = redirect_pc;
               state_d = imem.rvalid ? REQ : DRAIN;
            end else if (imem.rvalid) begin
               if (stall_IF) begin
                  hold_pc_d    = req_pc_q;
                  hold_instr_d = imem.rdata;
                  state_d      = HOLD;
               end else begin
                  xfer_vld   = 1'b1;
                  xfer_pc    = req_pc_q;
                  xfer_instr = imem.rdata;
                  imem.req   = 1'b1;
                  if (imem.gnt) begin
                     req_pc_d = pc_IF;
                     pc_d     = pc_IF + 32'd4;
                  end else begin
                     state_d = REQ;
                  end
               end
            end
         end
         HOLD: begin
            if (pc_change_EX) begin
               pc_d    = redirect_pc;
               state_d = REQ;
            end else if (!stall_IF) begin
               xfer_vld = 1'b1;
               state_d  = REQ;
            end
         end
         DRAIN: begin
            if (pc_change_EX) pc_d = redirect_pc;
            if (imem.rvalid) state_d = REQ;
         end
         default: state_d = REQ;
      endcase
   end

   if_id_reg #(.NOP(NOP)) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush_IF),
      .stall      (stall_IF),
      .load_valid (xfer_vld),
      .load_pc    (xfer_pc),
      .load_instr (xfer_instr),
      .valid      (valid_ID),
      .pc         (pc_ID),
      .instr      (instr_ID)
   );

endmodule
